// File: rtl/da_lut_builder_if.sv
// Handshake bundle between the DA LUT builder, its coefficient source and the
// downstream fir_filter LUT write port.
interface da_lut_builder_if #(
    parameter int unsigned COEF_W = 16,
    parameter int unsigned LUT_W  = 20
);
    logic              start;
    logic [COEF_W-1:0] coef_in;
    logic              coef_valid;
    logic              coef_ready;
    logic [LUT_W-1:0]  CIN;
    logic [10:0]       CADDR;
    logic              CLOAD;
    logic              wr_valid;
    logic              wr_ready;
    logic              done;

    modport master (
        output start, coef_in, coef_valid, wr_ready,
        input  coef_ready, CIN, CADDR, CLOAD, wr_valid, done
    );

    modport slave (
        input  start, coef_in, coef_valid, wr_ready,
        output coef_ready, CIN, CADDR, CLOAD, wr_valid, done
    );
endinterface

// File: rtl/da_lut_builder.sv
// Loads 64 signed coefficients, then streams the 8x256 distributed-arithmetic
// partial-sum LUT (one entry per accepted write) to a downstream fir_filter.
module da_lut_builder #(
    parameter int unsigned COEF_W = 16,
    parameter int unsigned N_TAPS = 64,
    parameter int unsigned LUT_W  = 20
) (
    input logic              clk_fast,
    input logic              resetn,
    da_lut_builder_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StBuild, StDone} state_e;

    state_e                    state_q, state_d;
    logic [5:0]                cnt_q, cnt_d;
    logic [10:0]               caddr_q, caddr_d;
    logic signed [LUT_W-1:0]   cin_q, cin_d;
    logic                      wr_valid_q, wr_valid_d;
    logic                      cload_q, cload_d;
    logic                      done_q, done_d;
    logic                      coef_ready_q, coef_ready_d;

    logic signed [COEF_W-1:0]  coef_q [N_TAPS];
    logic                      coef_we;
    logic [10:0]               addr_nxt;
    logic signed [LUT_W-1:0]   sum_nxt;

    // Partial sum for the entry following the one currently presented.
    always_comb begin
        addr_nxt = caddr_q + 11'd1;
        sum_nxt  = '0;
        for (int b = 0; b < 8; b++) begin
            if (addr_nxt[b]) begin
                sum_nxt = sum_nxt + LUT_W'(coef_q[{addr_nxt[10:8], 3'(b)}]);
            end
        end
    end

    assign coef_we = (state_q == StLoad) && bus.coef_valid && !bus.start;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        caddr_d      = caddr_q;
        cin_d        = cin_q;
        wr_valid_d   = wr_valid_q;
        cload_d      = cload_q;
        done_d       = done_q;
        coef_ready_d = coef_ready_q;

        if (bus.start) begin
            state_d      = StLoad;
            cnt_d        = '0;
            caddr_d      = '0;
            cin_d        = '0;
            wr_valid_d   = 1'b0;
            cload_d      = 1'b0;
            done_d       = 1'b0;
            coef_ready_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    if (bus.coef_valid) begin
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd63) begin
                            state_d      = StBuild;
                            coef_ready_d = 1'b0;
                            caddr_d      = '0;
                            cin_d        = '0;
                            wr_valid_d   = 1'b1;
                            cload_d      = 1'b1;
                        end
                    end
                end
                StBuild: begin
                    if (bus.wr_ready) begin
                        if (caddr_q == 11'h7ff) begin
                            state_d    = StDone;
                            wr_valid_d = 1'b0;
                            cload_d    = 1'b0;
                            done_d     = 1'b1;
                        end else begin
                            caddr_d = addr_nxt;
                            cin_d   = sum_nxt;
                        end
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_fast or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            caddr_q      <= '0;
            cin_q        <= '0;
            wr_valid_q   <= 1'b0;
            cload_q      <= 1'b0;
            done_q       <= 1'b0;
            coef_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            caddr_q      <= caddr_d;
            cin_q        <= cin_d;
            wr_valid_q   <= wr_valid_d;
            cload_q      <= cload_d;
            done_q       <= done_d;
            coef_ready_q <= coef_ready_d;
        end
    end

    // Coefficient storage is deliberately unreset; it is fully rewritten by LOAD.
    always_ff @(posedge clk_fast) begin
        if (coef_we) begin
            coef_q[cnt_q] <= bus.coef_in;
        end
    end

    assign bus.coef_ready = coef_ready_q;
    assign bus.CIN        = cin_q;
    assign bus.CADDR      = caddr_q;
    assign bus.CLOAD      = cload_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.done       = done_q;
endmodule
